// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit shared types: FSM states, access sizes, bus width.
// Size normalisation and lane-offset alignment helpers live here too.
package mem_access_unit_pkg;

  localparam int BUS = 32;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'd0,
    MAU_RD   = 2'd1,
    MAU_WR   = 2'd2,
    MAU_RESP = 2'd3
  } mau_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  // Reserved size behaves as a word access.
  function automatic logic [1:0] norm_size(
    input logic [1:0] sz
  );
    return (sz == SZ_R) ? SZ_W : sz;
  endfunction

  // Force low address bits to the natural alignment of the size.
  function automatic logic [1:0] align_off(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic [1:0] off;
    off = 2'b00;
    unique case (sz)
      SZ_B:    off = a;
      SZ_H:    off = {a[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/mau_lane.sv
// mau_lane: byte/half/word lane handling for the memory access unit.
// Extracts and extends load lanes; merges store data into the old word.
module mau_lane
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]     i_size,
  input  logic [1:0]     i_off,
  input  logic           i_unsigned,
  input  logic [BUS-1:0] i_old,
  input  logic [BUS-1:0] i_new,
  output logic [BUS-1:0] o_load,
  output logic [BUS-1:0] o_merge
);

  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic        w_bs;
  logic        w_hs;

  // Lane select, sign/zero extend, and read-modify-write merge.
  always_comb begin
    w_b     = i_old[{i_off, 3'b000} +: 8];
    w_h     = i_off[1] ? i_old[31:16] : i_old[15:0];
    w_bs    = ~i_unsigned & w_b[7];
    w_hs    = ~i_unsigned & w_h[15];
    o_load  = i_old;
    o_merge = i_new;
    unique case (i_size)
      SZ_B: begin
        o_load  = {{24{w_bs}}, w_b};
        o_merge = i_old;
        o_merge[{i_off, 3'b000} +: 8] = i_new[7:0];
      end
      SZ_H: begin
        o_load  = {{16{w_hs}}, w_h};
        o_merge = i_old;
        o_merge[{i_off[1], 4'b0000} +: 16] = i_new[15:0];
      end
      default: begin
        o_load  = i_old;
        o_merge = i_new;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for a word-wide memory.
// Optional MAU_MISALIGN_CHECK_EN flags misaligned/reserved accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic           clk,
  input  logic           RST_N,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [1:0]     req_size,
  input  logic           req_unsigned,
  input  logic [BUS-1:0] req_addr,
  input  logic [BUS-1:0] req_wdata,
  output logic           resp_valid,
  output logic [BUS-1:0] resp_rdata,
  output logic           resp_err,
  output logic [BUS-1:0] mem_addr,
  output logic [BUS-1:0] mem_waddr,
  output logic [BUS-1:0] mem_wdata,
  output logic           mem_we,
  input  logic [BUS-1:0] mem_rdata
);

  localparam logic [7:0] LP_LAST = 8'(MEM_RD_LAT);

  mau_state_e     r_state;
  mau_state_e     w_next;
  logic [7:0]     r_cnt;
  logic           r_we;
  logic           r_uns;
  logic [1:0]     r_size;
  logic [1:0]     r_off;
  logic [BUS-1:0] r_addr;
  logic [BUS-1:0] r_sdata;
  logic [BUS-1:0] r_wdata;
  logic [BUS-1:0] r_resp_rdata;
  logic           r_resp_valid;

  logic           w_acc;
  logic           w_bad;
  logic           w_last;
  logic           w_wstore;
  logic [1:0]     w_size;
  logic [1:0]     w_off;
  logic [BUS-1:0] w_load;
  logic [BUS-1:0] w_merge;

  assign req_ready  = (r_state == MAU_IDLE);
  assign w_acc      = req_valid & req_ready;
  assign w_size     = norm_size(req_size);
  assign w_off      = align_off(w_size, req_addr[1:0]);
  assign w_wstore   = req_we & (w_size == SZ_W);
  assign w_last     = (r_cnt == LP_LAST);

  assign mem_addr   = r_addr;
  assign mem_waddr  = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_we     = (r_state == MAU_WR) & RST_N;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;

`ifdef MAU_MISALIGN_CHECK_EN
  logic r_err;

  assign w_bad =
    ((req_size == SZ_H) & req_addr[0]) |
    ((req_size == SZ_W) & (req_addr[1:0] != 2'b00)) |
    (req_size == SZ_R);
  assign resp_err = r_err;

  // Error flag rides alongside the direct IDLE->RESP response.
  always_ff @(posedge clk) begin
    if (!RST_N) r_err <= 1'b0;
    else        r_err <= w_acc & w_bad;
  end
`else
  assign w_bad    = 1'b0;
  assign resp_err = 1'b0;
`endif

  mau_lane u_lane (
    .i_size     (r_size),
    .i_off      (r_off),
    .i_unsigned (r_uns),
    .i_old      (mem_rdata),
    .i_new      (r_sdata),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!RST_N) r_state <= MAU_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: word stores skip RD, sub-word stores read first.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MAU_IDLE: begin
        if (w_acc) begin
          if (w_bad)         w_next = MAU_RESP;
          else if (w_wstore) w_next = MAU_WR;
          else               w_next = MAU_RD;
        end
      end
      MAU_RD: begin
        if (w_last) w_next = r_we ? MAU_WR : MAU_RESP;
      end
      MAU_WR:   w_next = MAU_RESP;
      MAU_RESP: w_next = MAU_IDLE;
      default:  w_next = MAU_IDLE;
    endcase
  end

  // Request latch, read wait counter, merge and response registers.
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_size       <= SZ_B;
      r_off        <= 2'b00;
      r_addr       <= '0;
      r_sdata      <= '0;
      r_wdata      <= '0;
      r_resp_rdata <= '0;
      r_resp_valid <= 1'b0;
    end else begin
      if (w_acc) begin
        r_we    <= req_we;
        r_uns   <= req_unsigned;
        r_size  <= w_size;
        r_off   <= w_off;
        r_addr  <= {2'b00, req_addr[31:2]};
        r_sdata <= req_wdata;
        r_wdata <= req_wdata;
      end
      if ((r_state == MAU_RD) && !w_last)
        r_cnt <= r_cnt + 8'd1;
      else
        r_cnt <= '0;
      if ((r_state == MAU_RD) && w_last && r_we)
        r_wdata <= w_merge;
      if ((r_state == MAU_RD) && w_last && !r_we)
        r_resp_rdata <= w_load;
      else
        r_resp_rdata <= '0;
      r_resp_valid <= (w_next == MAU_RESP);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (MEM_RD_LAT 1 and 0 instances).
// Shared 16-word memory model with backdoor preload port.
module tb_mem_access_unit;

  logic        clk;
  logic        RST_N;
  logic        v0, v1;
  logic        we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;

  logic        rdy0, rdy1, rv0, rv1, err0, err1, mwe0, mwe1;
  logic [31:0] rd0, rd1, ma0, ma1, mwa0, mwa1, mwd0, mwd1;
  logic [31:0] mrd0, mrd1;

  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_data;
  logic [31:0] mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  int resp_cyc, resp_cnt, we_cnt, we_cyc, ready_cyc;
  logic [31:0] we_addr, we_data, r_data, rd_addr;
  logic        r_err;

  mem_access_unit #(.MEM_RD_LAT(1)) u_dut1 (
    .clk(clk), .RST_N(RST_N),
    .req_valid(v1), .req_ready(rdy1),
    .req_we(we), .req_size(size),
    .req_unsigned(uns), .req_addr(addr),
    .req_wdata(wdata),
    .resp_valid(rv1), .resp_rdata(rd1),
    .resp_err(err1),
    .mem_addr(ma1), .mem_waddr(mwa1),
    .mem_wdata(mwd1), .mem_we(mwe1),
    .mem_rdata(mrd1)
  );

  mem_access_unit #(.MEM_RD_LAT(0)) u_dut0 (
    .clk(clk), .RST_N(RST_N),
    .req_valid(v0), .req_ready(rdy0),
    .req_we(we), .req_size(size),
    .req_unsigned(uns), .req_addr(addr),
    .req_wdata(wdata),
    .resp_valid(rv0), .resp_rdata(rd0),
    .resp_err(err0),
    .mem_addr(ma0), .mem_waddr(mwa0),
    .mem_wdata(mwd0), .mem_we(mwe0),
    .mem_rdata(mrd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en)     mem[pl_idx] <= pl_data;
    else if (mwe1) mem[mwa1[3:0]] <= mwd1;
    else if (mwe0) mem[mwa0[3:0]] <= mwd0;
    mrd1 <= mem[ma1[3:0]];
  end
  assign mrd0 = mem[ma0[3:0]];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] i,
                         input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = i; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic issue(input bit d, input logic w,
                       input logic [1:0] s, input logic u,
                       input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    we = w; size = s; uns = u; addr = a; wdata = wd;
    if (d) v0 = 1'b1; else v1 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic observe(input bit d, input int ncyc);
    resp_cyc = 0; resp_cnt = 0; we_cnt = 0; we_cyc = 0;
    ready_cyc = 0; we_addr = '0; we_data = '0;
    r_data = '0; r_err = 1'b0; rd_addr = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) rd_addr = d ? ma0 : ma1;
      if (d ? mwe0 : mwe1) begin
        we_cnt++; we_cyc = c;
        we_addr = d ? mwa0 : mwa1;
        we_data = d ? mwd0 : mwd1;
      end
      if (d ? rv0 : rv1) begin
        resp_cnt++;
        if (resp_cyc == 0) begin
          resp_cyc = c;
          r_data = d ? rd0 : rd1;
          r_err  = d ? err0 : err1;
        end
      end
      if ((d ? rdy0 : rdy1) && ready_cyc == 0)
        ready_cyc = c;
    end
  endtask

  initial begin
    RST_N = 1'b0; v0 = 1'b0; v1 = 1'b0;
    we = 1'b0; uns = 1'b0; size = 2'b00;
    addr = '0; wdata = '0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready1", {31'b0, rdy1}, 32'd1);
    chk("rst_ready0", {31'b0, rdy0}, 32'd1);
    chk("rst_addr", ma1, 32'h0);
    chk("rst_wdata", mwd1, 32'h0);
    chk("rst_rv_we", {30'b0, rv1, mwe1}, 32'h0);
    chk("rst_rdata", rd1, 32'h0);
    chk("rst_err", {31'b0, err1}, 32'h0);
    preload(4'd1, 32'hDEADBEEF);
    @(negedge clk);
    RST_N = 1'b1;

    // word store
    issue(0, 1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFEF00D);
    observe(0, 5);
    chk("ws_wecnt", we_cnt, 1);
    chk("ws_wecyc", we_cyc, 1);
    chk("ws_waddr", we_addr, 32'h1);
    chk("ws_wdata", we_data, 32'hCAFEF00D);
    chk("ws_respcyc", resp_cyc, 2);
    chk("ws_rdata", r_data, 32'h0);
    chk("ws_ready", ready_cyc, 3);
    chk("ws_mem", mem[1], 32'hCAFEF00D);

    // byte loads
    preload(4'd1, 32'hDEADBEEF);
    issue(0, 1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
    observe(0, 5);
    chk("lbs_cyc", resp_cyc, 3);
    chk("lbs_data", r_data, 32'hFFFFFFBE);
    chk("lbs_addr", rd_addr, 32'h1);
    chk("lbs_nowe", we_cnt, 0);
    issue(0, 1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
    observe(0, 5);
    chk("lbu_data", r_data, 32'h000000BE);
    chk("lbu_cnt", resp_cnt, 1);

    // half store high lane, then byte store lane 0
    issue(0, 1'b1, 2'b01, 1'b0, 32'h6, 32'h00001234);
    observe(0, 6);
    chk("sh_rdaddr", rd_addr, 32'h1);
    chk("sh_wecnt", we_cnt, 1);
    chk("sh_wecyc", we_cyc, 3);
    chk("sh_wdata", we_data, 32'h1234BEEF);
    chk("sh_respcyc", resp_cyc, 4);
    chk("sh_ready", ready_cyc, 5);
    preload(4'd1, 32'hDEADBEEF);
    issue(0, 1'b1, 2'b00, 1'b0, 32'h4, 32'hFFFFFF55);
    observe(0, 6);
    chk("sb_wdata", we_data, 32'hDEADBE55);
    chk("sb_mem", mem[1], 32'hDEADBE55);

    // word load with zero read latency
    preload(4'd1, 32'hDEADBEEF);
    issue(1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    observe(1, 5);
    chk("l0_cyc", resp_cyc, 2);
    chk("l0_data", r_data, 32'hDEADBEEF);
    chk("l0_ready", ready_cyc, 3);

    // reserved size load on latency-1 unit
    issue(0, 1'b0, 2'b11, 1'b0, 32'h4, 32'h0);
    observe(0, 5);
`ifdef MAU_MISALIGN_CHECK_EN
    chk("rsv_err", {31'b0, r_err}, 32'd1);
    chk("rsv_cyc", resp_cyc, 1);
`else
    chk("rsv_data", r_data, 32'hDEADBEEF);
    chk("rsv_cyc", resp_cyc, 3);
`endif

    // misaligned half load
    issue(0, 1'b0, 2'b01, 1'b0, 32'h5, 32'h0);
    observe(0, 5);
`ifdef MAU_MISALIGN_CHECK_EN
    chk("mis_err", {31'b0, r_err}, 32'd1);
    chk("mis_cyc", resp_cyc, 1);
    chk("mis_data", r_data, 32'h0);
`else
    chk("mis_err", {31'b0, r_err}, 32'd0);
    chk("mis_cyc", resp_cyc, 3);
    chk("mis_data", r_data, 32'hFFFFBEEF);
`endif
    chk("mis_nowe", we_cnt, 0);

    // reset during RD of a byte store
    issue(0, 1'b1, 2'b00, 1'b0, 32'h4, 32'h00000055);
    @(negedge clk);
    chk("rr_we_c1", {31'b0, mwe1}, 32'h0);
    RST_N = 1'b0;
    @(negedge clk);
    RST_N = 1'b1;
    observe(0, 6);
    chk("rr_wecnt", we_cnt, 0);
    chk("rr_resp", resp_cnt, 0);
    chk("rr_ready", {31'b0, rdy1}, 32'd1);
    chk("rr_addr", ma1, 32'h0);
    chk("rr_wdata", mwd1, 32'h0);
    chk("rr_rdata", rd1, 32'h0);
    chk("rr_mem", mem[1], 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
